// File: rtl/minv_pkg.sv
// rtl/minv_pkg.sv - shared state type, default widths and word-count helper for the modular inverse unit
package minv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } minv_state_t;

    localparam int MINV_DEF_W = 16;
    localparam int MINV_DEF_N = 256;

    function automatic int minv_nw(input int n, input int w);
        return n / w;
    endfunction

endpackage

// File: rtl/minv_modp_alu.sv
// rtl/minv_modp_alu.sv - combinational modular subtract and modular halve for p odd, operands in [0,p)
module minv_modp_alu
    import minv_pkg::*;
#(
    parameter int N = MINV_DEF_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] p,
    input  logic [N-1:0] x,
    output logic [N-1:0] sub,
    output logic [N-1:0] half
);

    logic [N:0] diff;
    logic [N:0] sum;

    always_comb begin
        // a-b+p on borrow lands back in [0,p); the wrap of the N-bit add is intended
        diff = {1'b0, a} - {1'b0, b};
        sub  = diff[N] ? (diff[N-1:0] + p) : diff[N-1:0];
        // odd x: x+p is even (p odd), the extra carry bit keeps the sum exact
        sum  = {1'b0, x} + (x[0] ? {1'b0, p} : {(N+1){1'b0}});
        half = sum[N:1];
    end

endmodule

// File: rtl/minv_param.sv
// rtl/minv_param.sv - word-serial binary extended-gcd modular inverse with gcd readout and abort
module minv_param
    import minv_pkg::*;
#(
    parameter int W = MINV_DEF_W,
    parameter int N = MINV_DEF_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] datain,
    input  logic         loada,
    input  logic         loadp,
    input  logic         minv_en,
    input  logic         minv_abort,
    input  logic         outx1,
    input  logic         outx2,
    output logic [W-1:0] regx1out,
    output logic [W-1:0] regx2out,
    output logic         minv_rdy,
    output logic         minv_flag,
    output logic         minv_busy
);

    localparam int            NW     = minv_nw(N, W);
    localparam int            KW     = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [N-1:0]  ONE    = N'(1);
    localparam logic [KW-1:0] K_LAST = KW'(NW - 1);

    minv_state_t state, state_d;

    logic [N-1:0]  a_reg, p_reg, u_reg, v_reg, x1_reg, x2_reg, x_reg, g_reg;
    logic [KW-1:0] k1, k2;
    logic          flag;

    logic [N-1:0]  sub1, half1, sub2, half2;

    logic load_any, idle_or_done, load_ok, start_ok;
    logic u_one, v_one, uv_zero, run_finish;

    minv_modp_alu #(.N(N)) u_alu_x1 (
        .a    (x1_reg),
        .b    (x2_reg),
        .p    (p_reg),
        .x    (x1_reg),
        .sub  (sub1),
        .half (half1)
    );

    minv_modp_alu #(.N(N)) u_alu_x2 (
        .a    (x2_reg),
        .b    (x1_reg),
        .p    (p_reg),
        .x    (x2_reg),
        .sub  (sub2),
        .half (half2)
    );

    assign load_any     = loada | loadp;
    assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
    assign load_ok      = idle_or_done && load_any && !minv_abort;
    assign start_ok     = idle_or_done && minv_en && !load_any && !minv_abort;

    assign u_one      = (u_reg == ONE);
    assign v_one      = (v_reg == ONE);
    assign uv_zero    = (u_reg == '0) || (v_reg == '0);
    assign run_finish = u_one || v_one || uv_zero;

    always_comb begin
        state_d = state;
        if (minv_abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (load_any) begin
                        state_d = ST_IDLE;
                    end else if (minv_en) begin
                        // an even modulus has no odd-p gcd invariant; report non-invertible at once
                        state_d = p_reg[0] ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (run_finish) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            p_reg    <= '0;
            u_reg    <= '0;
            v_reg    <= '0;
            x1_reg   <= '0;
            x2_reg   <= '0;
            x_reg    <= '0;
            g_reg    <= '0;
            k1       <= '0;
            k2       <= '0;
            regx1out <= '0;
            regx2out <= '0;
            flag     <= 1'b0;
        end else if (minv_abort) begin
            flag <= 1'b0;
        end else if (load_ok) begin
            // shift in from the top so the first word loaded ends up least significant
            if (loada) a_reg <= N'({datain, a_reg} >> W);
            if (loadp) p_reg <= N'({datain, p_reg} >> W);
            flag <= 1'b0;
        end else if (start_ok) begin
            u_reg  <= a_reg;
            v_reg  <= p_reg;
            x1_reg <= ONE;
            x2_reg <= '0;
            k1     <= '0;
            k2     <= '0;
            flag   <= 1'b0;
            if (!p_reg[0]) begin
                x_reg <= '0;
                g_reg <= '0;
            end
        end else if (state == ST_RUN) begin
            // invariants: x1*a == u and x2*a == v (mod p), x1,x2 in [0,p)
            if (u_one) begin
                x_reg <= x1_reg;
                g_reg <= ONE;
                flag  <= 1'b1;
                k1    <= '0;
                k2    <= '0;
            end else if (v_one) begin
                x_reg <= x2_reg;
                g_reg <= ONE;
                flag  <= 1'b1;
                k1    <= '0;
                k2    <= '0;
            end else if (uv_zero) begin
                x_reg <= '0;
                g_reg <= u_reg | v_reg;
                flag  <= 1'b0;
                k1    <= '0;
                k2    <= '0;
            end else if (!u_reg[0]) begin
                u_reg  <= u_reg >> 1;
                x1_reg <= half1;
            end else if (!v_reg[0]) begin
                v_reg  <= v_reg >> 1;
                x2_reg <= half2;
            end else if (u_reg >= v_reg) begin
                u_reg  <= u_reg - v_reg;
                x1_reg <= sub1;
            end else begin
                v_reg  <= v_reg - u_reg;
                x2_reg <= sub2;
            end
        end else if (state == ST_DONE) begin
            if (outx1) begin
                regx1out <= W'(x_reg >> (int'(k1) * W));
                k1       <= (k1 == K_LAST) ? '0 : k1 + KW'(1);
            end
            if (outx2) begin
                regx2out <= W'(g_reg >> (int'(k2) * W));
                k2       <= (k2 == K_LAST) ? '0 : k2 + KW'(1);
            end
        end
    end

    assign minv_rdy  = (state == ST_DONE);
    assign minv_busy = (state == ST_RUN);
    assign minv_flag = flag;

endmodule

// File: tb/tb_minv_param.sv
// tb/tb_minv_param.sv - randomized and directed bench for minv_param at 4/8 and 16/256 widths
module tb_minv_param;

    logic        clk = 1'b0;
    logic        rst, sel;
    logic [15:0] din;
    logic        loada, loadp, en, abort_r, ox1, ox2;

    logic [3:0]  s_x1, s_x2;
    logic        s_rdy, s_flag, s_busy;
    logic [15:0] b_x1, b_x2;
    logic        b_rdy, b_flag, b_busy;

    logic [15:0] x1o, x2o;
    logic        rdy, flag, busy;

    int total = 0;
    int bad   = 0;
    int w, n, nw;

    always #5 clk = ~clk;

    minv_param #(.W(4), .N(8)) u_small (
        .clk        (clk),
        .rst        (rst),
        .datain     (din[3:0]),
        .loada      (loada & ~sel),
        .loadp      (loadp & ~sel),
        .minv_en    (en & ~sel),
        .minv_abort (abort_r & ~sel),
        .outx1      (ox1 & ~sel),
        .outx2      (ox2 & ~sel),
        .regx1out   (s_x1),
        .regx2out   (s_x2),
        .minv_rdy   (s_rdy),
        .minv_flag  (s_flag),
        .minv_busy  (s_busy)
    );

    minv_param #(.W(16), .N(256)) u_big (
        .clk        (clk),
        .rst        (rst),
        .datain     (din),
        .loada      (loada & sel),
        .loadp      (loadp & sel),
        .minv_en    (en & sel),
        .minv_abort (abort_r & sel),
        .outx1      (ox1 & sel),
        .outx2      (ox2 & sel),
        .regx1out   (b_x1),
        .regx2out   (b_x2),
        .minv_rdy   (b_rdy),
        .minv_flag  (b_flag),
        .minv_busy  (b_busy)
    );

    always_comb begin
        x1o  = sel ? b_x1 : {12'd0, s_x1};
        x2o  = sel ? b_x2 : {12'd0, s_x2};
        rdy  = sel ? b_rdy : s_rdy;
        flag = sel ? b_flag : s_flag;
        busy = sel ? b_busy : s_busy;
    end

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // extended Euclid on plain integers: inverse via Bezout coefficient, gcd via remainders
    function automatic void model(input logic [511:0] a, input logic [511:0] p,
                                  output logic [511:0] x, output logic [511:0] g, output bit f);
        logic signed [527:0] r0, r1, t0, t1, q, tmp;
        x = '0; g = '0; f = 1'b0;
        if (p[0] == 1'b0) return;
        r0 = {16'd0, p};
        r1 = {16'd0, a % p};
        t0 = '0;
        t1 = 528'sd1;
        while (r1 != 0) begin
            q   = r0 / r1;
            tmp = r0 - q * r1; r0 = r1; r1 = tmp;
            tmp = t0 - q * t1; t0 = t1; t1 = tmp;
        end
        g = r0[511:0];
        if (g == 512'd1) begin
            f = 1'b1;
            if (t0 < 0) t0 = t0 + {16'd0, p};
            x = t0[511:0];
        end
    endfunction

    function automatic logic [511:0] rnd256();
        logic [511:0] v = '0;
        for (int i = 0; i < 8; i++) v = v | (512'($urandom) << (32 * i));
        return v;
    endfunction

    task automatic use_dut(input bit s);
        @(negedge clk);
        sel = s;
        w   = s ? 16 : 4;
        n   = s ? 256 : 8;
        nw  = n / w;
    endtask

    task automatic load_reg(input bit is_p, input logic [511:0] v);
        logic [511:0] mask;
        mask = (512'd1 << w) - 512'd1;
        for (int i = 0; i < nw; i++) begin
            @(negedge clk);
            din   = 16'((v >> (i * w)) & mask);
            loada = !is_p;
            loadp = is_p;
        end
        @(negedge clk);
        loada = 1'b0;
        loadp = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    // cyc counts clock edges since the edge that sampled minv_en
    task automatic wait_rdy(inout int cyc, output int busy_cnt);
        busy_cnt = 0;
        while (!rdy && cyc < 4 * n + 10) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic read_out(input int count, output logic [511:0] x, output logic [511:0] g,
                            output logic [15:0] lx1, output logic [15:0] lx2);
        x = '0; g = '0;
        @(negedge clk);
        ox1 = 1'b1;
        ox2 = 1'b1;
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            if (i < nw) begin
                x = x | (512'(x1o) << (i * w));
                g = g | (512'(x2o) << (i * w));
            end
            lx1 = x1o;
            lx2 = x2o;
        end
        ox1 = 1'b0;
        ox2 = 1'b0;
    endtask

    task automatic run_case(input string tag, input logic [511:0] a, input logic [511:0] p,
                            input logic [511:0] ex, input logic [511:0] eg, input bit ef,
                            output int cyc);
        int           bc;
        logic [511:0] x, g;
        logic [15:0]  l1, l2;
        load_reg(1'b0, a);
        load_reg(1'b1, p);
        pulse_start();
        cyc = 1;
        wait_rdy(cyc, bc);
        check_val({tag, "/rdy"}, 512'(rdy), 512'd1);
        check_val({tag, "/flag"}, 512'(flag), 512'(ef));
        check_val({tag, "/lat"}, 512'(cyc <= 4 * n + 2), 512'd1);
        check_val({tag, "/busy_cycles"}, 512'(bc), 512'(cyc - 1));
        read_out(nw, x, g, l1, l2);
        check_val({tag, "/x"}, x, ex);
        check_val({tag, "/g"}, g, eg);
        check_val({tag, "/rdy_hold"}, 512'(rdy), 512'd1);
    endtask

    initial begin
        int           cyc, bc;
        logic [511:0] a, p, ex, eg, x, g;
        logic [15:0]  l1, l2, prev1, prev2;
        bit           ef;

        rst = 1'b1; sel = 1'b0; din = '0;
        loada = 1'b0; loadp = 1'b0; en = 1'b0; abort_r = 1'b0; ox1 = 1'b0; ox2 = 1'b0;
        w = 4; n = 8; nw = 2;
        repeat (3) @(negedge clk);
        check_val("reset/small", {s_x1, s_x2, s_rdy, s_flag, s_busy}, '0);
        check_val("reset/big", {b_x1, b_x2, b_rdy, b_flag, b_busy}, '0);
        rst = 1'b0;

        use_dut(1'b0);
        run_case("a5p11", 5, 11, 9, 1, 1'b1, cyc);
        run_case("a6p9", 6, 9, 0, 3, 1'b0, cyc);
        run_case("a0p11", 0, 11, 0, 11, 1'b0, cyc);
        run_case("a1p11", 1, 11, 1, 1, 1'b1, cyc);
        check_val("a1p11/run_cycles_le2", 512'(cyc - 1 <= 2), 512'd1);
        run_case("a5p10", 5, 10, 0, 0, 1'b0, cyc);
        check_val("p_even/one_cycle", 512'(cyc), 512'd1);

        // unload wrap: NW+1 reads return LSW..MSW then word 0 again
        run_case("a5p11_b", 5, 11, 9, 1, 1'b1, cyc);
        read_out(nw + 1, x, g, l1, l2);
        check_val("unload/x", x, 512'h09);
        check_val("unload/wrap_x1", 512'(l1), 512'h9);
        check_val("unload/wrap_x2", 512'(l2), 512'h1);

        // a load in DONE drops rdy/flag
        @(negedge clk); din = 16'h3; loada = 1'b1;
        @(negedge clk); loada = 1'b0;
        check_val("load_in_done/rdy", 512'(rdy), 512'd0);
        check_val("load_in_done/flag", 512'(flag), 512'd0);

        // start coincident with a load is ignored
        @(negedge clk); en = 1'b1; loadp = 1'b1; din = 16'h5;
        @(negedge clk); en = 1'b0; loadp = 1'b0;
        @(negedge clk);
        check_val("en_with_load/busy", 512'(busy), 512'd0);
        check_val("en_with_load/rdy", 512'(rdy), 512'd0);

        // unload strobes during RUN leave the output registers alone
        prev1 = x1o; prev2 = x2o;
        load_reg(1'b0, 7);
        load_reg(1'b1, 11);
        pulse_start();
        ox1 = 1'b1; ox2 = 1'b1;
        @(negedge clk);
        ox1 = 1'b0; ox2 = 1'b0;
        check_val("out_in_run/x1", 512'(x1o), 512'(prev1));
        check_val("out_in_run/x2", 512'(x2o), 512'(prev2));
        cyc = 2;
        wait_rdy(cyc, bc);
        check_val("a7p11/rdy", 512'(rdy), 512'd1);
        read_out(nw + 1, x, g, l1, l2);
        check_val("a7p11/x", x, 512'h08);
        check_val("a7p11/g", g, 512'h01);

        // reset mid-RUN
        load_reg(1'b0, 3);
        pulse_start();
        check_val("pre_reset/busy", 512'(busy), 512'd1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_val("reset_run/state", {496'd0, x1o[3:0], x2o[3:0], rdy, flag, busy}, '0);
        pulse_start();
        check_val("reset_run/p_cleared_even", 512'(rdy), 512'd1);

        for (int i = 0; i < 40; i++) begin
            a = 512'($urandom_range(255, 0));
            p = 512'($urandom_range(255, 2));
            model(a, p, ex, eg, ef);
            run_case($sformatf("rnd8_%0d", i), a, p, ex, eg, ef, cyc);
        end

        use_dut(1'b1);
        for (int i = 0; i < 3; i++) begin
            a = rnd256();
            p = rnd256() | 512'd1;
            p[255] = (i != 2);
            model(a, p, ex, eg, ef);
            run_case($sformatf("rnd256_%0d", i), a, p, ex, eg, ef, cyc);
            if (ef) check_val($sformatf("rnd256_%0d/inv_prop", i), ((a % p) * ex) % p, 512'd1);
        end
        a = rnd256();
        p = rnd256() & ~512'd1;
        run_case("big_even_p", a, p, 0, 0, 1'b0, cyc);

        // abort part-way, with a load in the same cycle, then restart without reload
        a = rnd256();
        p = rnd256() | 512'd1;
        p[255] = 1'b1;
        model(a, p, ex, eg, ef);
        load_reg(1'b0, a);
        load_reg(1'b1, p);
        pulse_start();
        repeat (19) @(negedge clk);
        check_val("abort/busy_before", 512'(busy), 512'd1);
        abort_r = 1'b1; loada = 1'b1; din = 16'hbeef;
        @(negedge clk);
        abort_r = 1'b0; loada = 1'b0;
        check_val("abort/busy", 512'(busy), 512'd0);
        check_val("abort/rdy", 512'(rdy), 512'd0);
        pulse_start();
        cyc = 1;
        wait_rdy(cyc, bc);
        check_val("restart/rdy", 512'(rdy), 512'd1);
        check_val("restart/flag", 512'(flag), 512'(ef));
        check_val("restart/lat", 512'(cyc <= 4 * n + 2), 512'd1);
        read_out(nw, x, g, l1, l2);
        check_val("restart/x", x, ex);
        check_val("restart/g", g, eg);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
